// File: rtl/mealy_stimulus_tx.sv
// Serial stimulus transmitter for the Mealy detector: shifts a loaded pattern out MSB-first, one bit per clock.
// Optional detector hit counter is enabled by defining MEALY_TX_HIT_COUNT_EN.
module mealy_stimulus_tx #(
    parameter int WIDTH = 16,
    parameter int LW    = 5,
    parameter int CW    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    length,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             done,
    input  logic             z,
    output logic [CW-1:0]    hit_count,
    output logic             dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [LW-1:0] W_LEN = LW'(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [LW-1:0]    r_rem;
    logic [LW-1:0]    w_rem_nxt;
    logic             r_x;
    logic             r_x_valid;
    logic             r_done;
    logic [LW-1:0]    w_len_eff;
    logic [WIDTH-1:0] w_aligned;
    logic             w_accept;

    // Handshake: a frame is accepted on any rising edge with load && ready; ready is
    // high in IDLE and on the last-bit cycle of a frame, so frames can chain without gaps.
    assign ready    = (r_state == IDLE) || (r_rem == LW'(1));
    assign w_accept = load && ready;

    always_comb begin
        w_len_eff = length;
        if ((length == '0) || (length > W_LEN)) begin
            w_len_eff = W_LEN;
        end
        // Left shift drops pattern bits above the active field.
        w_aligned = pattern << (W_LEN - w_len_eff);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_rem_nxt   = r_rem;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SHIFT;
                    w_shift_nxt = w_aligned;
                    w_rem_nxt   = w_len_eff;
                end
            end
            SHIFT: begin
                if (w_accept) begin
                    w_shift_nxt = w_aligned;
                    w_rem_nxt   = w_len_eff;
                end else begin
                    w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
                    w_rem_nxt   = r_rem - LW'(1);
                    if (r_rem == LW'(1)) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_rem     <= '0;
            r_x       <= 1'b0;
            r_x_valid <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_rem     <= w_rem_nxt;
            r_x       <= (w_state_nxt == SHIFT) && w_shift_nxt[WIDTH-1];
            r_x_valid <= (w_state_nxt == SHIFT);
            r_done    <= (w_state_nxt == SHIFT) && (w_rem_nxt == LW'(1));
        end
    end

    assign x         = r_x;
    assign x_valid   = r_x_valid;
    assign done      = r_done;
    assign dbg_state = r_state;

`ifdef MEALY_TX_HIT_COUNT_EN
    logic [CW-1:0] r_hit_count;

    // Saturating; counts the detector output only while a frame bit is on x.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit_count <= '0;
        end else if (r_x_valid && z && (r_hit_count != {CW{1'b1}})) begin
            r_hit_count <= r_hit_count + CW'(1);
        end
    end

    assign hit_count = r_hit_count;
`else
    logic w_unused_z;

    assign w_unused_z = z;
    assign hit_count  = '0;
`endif

endmodule

// File: tb/tb_mealy_stimulus_tx.sv
// Bench for mealy_stimulus_tx: table-driven vectors, hand-written corner sequences,
// and randomized traffic checked against a queue-based frame model.
module tb_mealy_stimulus_tx;

    localparam int WIDTH = 16;
    localparam int LW    = 5;
    localparam int CW    = 2;
    localparam int HMAX  = (1 << CW) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] pattern;
    logic [LW-1:0]    length;
    logic             ready;
    logic             x;
    logic             x_valid;
    logic             done;
    logic             z;
    logic [CW-1:0]    hit_count;
    logic             dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: bits still to appear on x, front is the bit currently driven.
    logic [0:0] exp_q[$];
    int         m_hits = 0;

    typedef struct {
        logic             rst;
        logic             ld;
        logic [WIDTH-1:0] pat;
        logic [LW-1:0]    len;
        logic             ex;
        logic             ev;
        logic             ed;
        logic             er;
    } vec_t;

    vec_t vecs[$];

    mealy_stimulus_tx #(.WIDTH(WIDTH), .LW(LW), .CW(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .pattern   (pattern),
        .length    (length),
        .ready     (ready),
        .x         (x),
        .x_valid   (x_valid),
        .done      (done),
        .z         (z),
        .hit_count (hit_count),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, sample 1ns after it.
    task automatic tick(input logic rst, input logic ld, input logic [WIDTH-1:0] pat,
                        input logic [LW-1:0] len, input logic zz);
        int   eff;
        logic m_ready;
        reset   = rst;
        load    = ld;
        pattern = pat;
        length  = len;
        z       = zz;
        m_ready = (exp_q.size() <= 1);
        @(posedge clock);
        if (rst) begin
            exp_q.delete();
            m_hits = 0;
        end else begin
`ifdef MEALY_TX_HIT_COUNT_EN
            if ((exp_q.size() > 0) && zz && (m_hits < HMAX)) m_hits++;
`endif
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (ld && m_ready) begin
                eff = ((len == 0) || (int'(len) > WIDTH)) ? WIDTH : int'(len);
                for (int i = eff - 1; i >= 0; i--) exp_q.push_back(pat[i]);
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_x"},       int'(x),         (exp_q.size() > 0) ? int'(exp_q[0]) : 0);
        check({tag, "_x_valid"}, int'(x_valid),   int'(exp_q.size() > 0));
        check({tag, "_done"},    int'(done),      int'(exp_q.size() == 1));
        check({tag, "_ready"},   int'(ready),     int'(exp_q.size() <= 1));
        check({tag, "_hits"},    int'(hit_count), m_hits);
    endtask

    task automatic add_vec(input logic rst, input logic ld, input logic [WIDTH-1:0] pat,
                           input logic [LW-1:0] len, input logic ex, input logic ev,
                           input logic ed, input logic er);
        vec_t v;
        v.rst = rst; v.ld = ld; v.pat = pat; v.len = len;
        v.ex = ex; v.ev = ev; v.ed = ed; v.er = er;
        vecs.push_back(v);
    endtask

    // A load vector followed by one vector per remaining bit; glitch_k places an
    // extra load request (which must be ignored) on that vector.
    task automatic add_frame(input logic [WIDTH-1:0] pat, input logic [LW-1:0] len,
                             input int eff, input logic [WIDTH-1:0] bits, input int glitch_k);
        for (int i = 0; i < eff; i++) begin
            if (i == 0)
                add_vec(1'b0, 1'b1, pat, len, bits[eff-1], 1'b1, eff == 1, eff == 1);
            else if (i == glitch_k)
                add_vec(1'b0, 1'b1, 16'hFFFF, 5'd4, bits[eff-1-i], 1'b1, i == eff - 1, i == eff - 1);
            else
                add_vec(1'b0, 1'b0, '0, '0, bits[eff-1-i], 1'b1, i == eff - 1, i == eff - 1);
        end
    endtask

    task automatic add_idle();
        add_vec(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [WIDTH-1:0] bits13;
        logic [WIDTH-1:0] bits16;
        reset = 1'b1; load = 1'b0; pattern = '0; length = '0; z = 1'b0;

        bits13 = 16'b0000_0010_0110_0100_1;
        bits13 = 16'b0000001001100100 >> 0;
        bits13 = 16'h04C9;
        bits16 = 16'b1010010111000011;

        add_vec(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_frame(16'h04C9, 5'd13, 13, bits13, -1);
        add_idle();
        add_frame(16'hA5C3, 5'd0, 16, bits16, -1);
        add_idle();
        add_frame(16'hFFF5, 5'd3, 3, 16'b101, -1);
        add_frame(16'hFFF1, 5'd2, 2, 16'b01, -1);
        add_idle();
        add_frame(16'h000D, 5'd4, 4, 16'b1101, 2);
        add_idle();
        add_idle();
        add_frame(16'h0006, 5'd31, 16, 16'h0006, -1);
        add_idle();

        @(negedge clock);
        foreach (vecs[k]) begin
            tick(vecs[k].rst, vecs[k].ld, vecs[k].pat, vecs[k].len, 1'b0);
            check($sformatf("vec%0d_x", k),       int'(x),       int'(vecs[k].ex));
            check($sformatf("vec%0d_x_valid", k), int'(x_valid), int'(vecs[k].ev));
            check($sformatf("vec%0d_done", k),    int'(done),    int'(vecs[k].ed));
            check($sformatf("vec%0d_ready", k),   int'(ready),   int'(vecs[k].er));
        end

        // Reset on bit 5 of a 13-bit frame, with load also high.
        tick(1'b1, 1'b0, '0, '0, 1'b0);
        tick(1'b0, 1'b1, 16'h04C9, 5'd13, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, '0, '0, 1'b0);
        check("rst_mid_pre_valid", int'(x_valid), 1);
        tick(1'b1, 1'b1, 16'hFFFF, 5'd13, 1'b0);
        check("rst_mid_x",       int'(x),       0);
        check("rst_mid_x_valid", int'(x_valid), 0);
        check("rst_mid_ready",   int'(ready),   1);
        check("rst_mid_done",    int'(done),    0);
        tick(1'b0, 1'b0, '0, '0, 1'b0);
        check("rst_mid_no_frame", int'(x_valid), 0);

        // Hit counter: z while idle must not count; then five valid cycles with z high.
        tick(1'b0, 1'b0, '0, '0, 1'b1);
        tick(1'b0, 1'b0, '0, '0, 1'b1);
        check("hit_idle", int'(hit_count), 0);
        tick(1'b0, 1'b1, 16'h00FF, 5'd8, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick(1'b0, 1'b0, '0, '0, 1'b1);
`ifdef MEALY_TX_HIT_COUNT_EN
            check($sformatf("hit_sat_%0d", k), int'(hit_count), (k < HMAX) ? k : HMAX);
`else
            check($sformatf("hit_off_%0d", k), int'(hit_count), 0);
`endif
        end
        tick(1'b1, 1'b0, '0, '0, 1'b0);
        check("hit_reset", int'(hit_count), 0);

        // Randomized traffic against the queue model.
        for (int c = 0; c < 3000; c++) begin
            tick(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
                 WIDTH'($urandom), LW'($urandom_range(0, 31)), ($urandom_range(0, 1) == 1));
            check_model($sformatf("rnd%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mealy_stimulus_tx.md
# mealy_stimulus_tx

Serial stimulus transmitter for the Mealy sequence detector: accepts a parallel bit pattern through a ready/load handshake and drives it MSB-first onto the detector's `x` input, one bit per `clock`. It sits in front of the detector, replacing hand-scheduled testbench stimulus, and can stream frames back-to-back without gap bits. An optional hit counter observes the detector's `z` output while bits are being driven.

## Interface
- `WIDTH`, 16: maximum pattern length in bits.
- `LW`, 5: width of `length`; must satisfy 2^LW > WIDTH.
- `CW`, 8: width of `hit_count`.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset; one clock, sampled on the rising edge of `clock`.
- `load`  in  1  load request; accepted on a rising edge where `load && ready`.
- `pattern`  in  WIDTH  frame bits; active field is `pattern[length-1:0]`, sent MSB of the field first.
- `length`  in  LW  bits to send, 1..WIDTH; 0 or any value > WIDTH is treated as WIDTH.
- `ready`  out  1  block can accept a load this cycle.
- `x`  out  1  serial bit to the detector.
- `x_valid`  out  1  `x` carries a frame bit this cycle.
- `done`  out  1  one-cycle pulse on the cycle the last frame bit is driven.
- `z`  in  1  detector output, observed only when `MEALY_TX_HIT_COUNT_EN` is defined.
- `hit_count`  out  CW  detector hits seen during valid bits.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE:
  - `x`=0, `x_valid`=0, `ready`=1.
  - An accepted load captures `pattern` left-aligned into a WIDTH-bit shift register and the effective length into a bit counter `rem`, then moves to SHIFT.
- SHIFT:
  - `x` = shift register MSB, `x_valid`=1.
  - Each cycle the register shifts left, zero-fill, and `rem` decrements.
- Last bit is the cycle with `rem`==1. On that cycle:
  - `done`=1 and `ready`=1.
  - Load accepted on this cycle: reload and stay in SHIFT; first bit of the new frame follows with no gap.
  - No load: return to IDLE.
- `ready`=0 in SHIFT except on the last-bit cycle. `load` while `ready`=0 is ignored and not queued.
- `pattern` and `length` are sampled only at acceptance; later changes have no effect on the frame in flight.
- Reset, in any state including mid-frame, on the next rising edge:
  - State becomes IDLE; `x`=0, `x_valid`=0, `ready`=1, `done`=0, `hit_count`=0.
  - Shift register and `rem` cleared; the partial frame is abandoned.
  - Reset has priority over a simultaneous `load`.

## Timing
- All outputs are registered except `ready`, which decodes from state and `rem`.
- Load accepted at edge N: first bit on `x` valid from edge N to edge N+1. A frame of L bits occupies cycles N..N+L-1 after the accepting edge.
- `done` is coincident with bit L. `ready` is high in that same cycle.
- Idle-to-idle, a single frame with no follow-on load costs L cycles of `x_valid` plus one IDLE cycle.
- Detector alignment: the detector samples `x` on the edge ending each valid cycle.

## Configuration
- `MEALY_TX_HIT_COUNT_EN` defined:
  - `hit_count` increments on each rising edge where `x_valid && z`.
  - Saturates at 2^CW-1.
  - Cleared only by reset, not by new loads.
- Not defined:
  - `z` is ignored.
  - `hit_count` is constant 0.
  - No counter logic is synthesized.

## Test plan
- Reset then load, `pattern`=13'b0010011001001, `length`=13:
  - `x` reads 0,0,1,0,0,1,1,0,0,1,0,0,1 on consecutive cycles, `x_valid`=1 throughout.
  - `done` is high only on the 13th bit; next cycle `x_valid`=0 and `ready`=1.
- `length`=0 with `pattern`=16'hA5C3: 16 bits sent, 1010010111000011; `done` on the 16th bit.
- Back-to-back:
  - Load 3'b101 (length 3); assert `load` on its last-bit cycle with 2'b01 (length 2).
  - `x` = 1,0,1,0,1 contiguous; `x_valid` never drops; `done` pulses on bits 3 and 5.
- `load` asserted on the 2nd bit of a 4-bit frame: ignored; frame completes unchanged and no new frame starts.
- Reset asserted on bit 5 of the 13-bit frame with `load` also high:
  - Next cycle `x`=0, `x_valid`=0, `ready`=1, `done`=0.
  - No frame starts.
- With `MEALY_TX_HIT_COUNT_EN` defined and CW=2:
  - Drive `z`=1 for 5 valid cycles: `hit_count` reads 1,2,3,3,3.
  - `z`=1 while `x_valid`=0 does not count.
  - Without the macro, `hit_count` stays 0.
